spi_burst_controller: RTL and testbench
=======================================

Name: spi_burst_controller

Overview:
- Command and buffering stage directly upstream of spi_master.
- Accepts host commands (address, read/write, word count) over a valid/ready port. Buffers write words in a write FIFO and read words in a read FIFO.
- Drives the master's enable, address, data and burst inputs.
- Services the master's burst write-word requests and burst read-valid strobes without host involvement.

Parameters:
- FIFO_DEPTH, 16, words per FIFO (power of two, ≥2).
- FIFO_AW, 4, log2(FIFO_DEPTH).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_cmd_valid  in  1  host command valid.
- o_cmd_ready  out  1  high only in IDLE.
- i_cmd_addr  in  15  SPI address.
- i_cmd_rw  in  1  1=read, 0=write.
- i_cmd_count  in  16  words in transaction; 0 treated as 1.
- i_wr_data  in  16  write word to FIFO.
- i_wr_valid  in  1  push write word.
- o_wr_ready  out  1  write FIFO not full.
- o_rd_data  out  16  head of read FIFO.
- o_rd_valid  out  1  read FIFO not empty.
- i_rd_ready  in  1  pop read word.
- o_done  out  1  one-cycle pulse at transaction end.
- o_underflow_err  out  1  sticky; write word requested while write FIFO empty.
- o_overflow_err  out  1  sticky; read word arrived while read FIFO full.
- i_err_clear  in  1  clears both sticky errors.
- o_spi_enable  out  1  to master i_enable.
- o_spi_addr  out  15  to master i_addr.
- o_spi_rw  out  1  to master i_rw.
- o_spi_data  out  16  to master i_data.
- o_spi_burst_enable  out  1  to master i_burst_enable.
- o_spi_burst_count  out  16  to master i_burst_count.
- i_spi_busy  in  1  from master o_busy.
- i_spi_read_word  in  16  from master o_read_word.
- i_spi_burst_read_valid  in  1  from master o_burst_read_data_valid.
- i_spi_burst_write_req  in  1  from master o_burst_write_word_request.

Behaviour:
- Reset (async, i_rst=1): state IDLE; both FIFOs emptied; all outputs 0 except o_cmd_ready=1 and o_wr_ready=1. Reset mid-transaction abandons it; no o_done.
- Edge detectors: registered copies of i_spi_busy, i_spi_burst_read_valid and i_spi_burst_write_req, all reset to 0. "Rise" means current=1 and previous=0; "fall" means current=0 and previous=1.
- IDLE: on i_cmd_valid & o_cmd_ready, latch the command.
  - o_spi_addr = i_cmd_addr; o_spi_rw = i_cmd_rw.
  - eff = max(i_cmd_count, 1); o_spi_burst_count = eff; o_spi_burst_enable = (eff > 1).
  - Next state: rw=0 → PREFETCH; rw=1 → START with o_spi_data=0.
- PREFETCH: wait until the write FIFO is non-empty, then pop the head into o_spi_data and go to START. Pop and o_spi_data load occur in the same cycle.
- START: o_spi_enable=1; hold until a rise of i_spi_busy is seen, then o_spi_enable=0 and go to RUN. Enable must drop before the master returns to idle, otherwise it restarts.
- RUN:
  - On a rise of i_spi_burst_write_req: pop the write FIFO into o_spi_data the next cycle. If the FIFO is empty, load 0x0000 and set o_underflow_err. o_spi_data then stays stable until the next rise.
  - On a rise of i_spi_burst_read_valid (burst read only): push i_spi_read_word into the read FIFO. If the FIFO is full, drop the word and set o_overflow_err.
  - On a fall of i_spi_busy:
    - Non-burst read: push i_spi_read_word, with the same overflow rule.
    - Then go to DONE.
- DONE: o_done=1 for one cycle, then IDLE.
- o_spi_addr, o_spi_rw, o_spi_burst_* remain stable from command latch to DONE.
- FIFOs: registered, first-word-fall-through. Simultaneous push and pop is allowed when neither full nor empty; occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty. Push-when-full and pop-when-empty are ignored at the FIFO.
- Host pushes to the write FIFO are allowed in any state.
- If i_err_clear coincides with a new error event, the error wins.

Decomposition:
- Shared package spi_ctrl_pkg:
  - state encodings IDLE/PREFETCH/START/RUN/DONE as 3-bit constants;
  - SPI_ADDR_W=15, SPI_DATA_W=16, SPI_COUNT_W=16.
- One sub-module: sync_fifo (parameterised width/depth, FWFT, async active-high reset), instantiated twice.

Test Plan:
- Single write: cmd addr=0x1234, rw=0, count=1; FIFO holds 0xBEEF → o_spi_data=0xBEEF before enable; enable drops after busy rises; o_done one cycle after busy falls; FIFO empty.
- Burst write: count=3; FIFO holds 0x0001, 0x0002, 0x0003 → burst_enable=1, burst_count=3; each write-req rise loads the next word in order; no underflow.
- Burst write underflow: count=2, FIFO holds one word → on request, o_spi_data=0x0000 and o_underflow_err=1 until i_err_clear.
- Burst read: rw=1, count=4; model returns 0xA000..0xA003 → read FIFO holds four words in order; o_rd_valid high; o_done fires once.
- Read overflow: FIFO_DEPTH=2, count=3, i_rd_ready=0 → two words kept, third dropped, o_overflow_err=1.
- Async reset asserted in RUN → next cycle: state IDLE, o_spi_enable=0, FIFOs empty, o_cmd_ready=1, no o_done.

Source files
------------

// File: rtl/spi_burst_controller_pkg.sv
// Shared types and widths for the SPI burst command/buffer stage.
package spi_ctrl_pkg;
  localparam int SPI_ADDR_W  = 15;
  localparam int SPI_DATA_W  = 16;
  localparam int SPI_COUNT_W = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREFETCH = 3'd1,
    START    = 3'd2,
    RUN      = 3'd3,
    DONE     = 3'd4
  } state_t;

  // A zero word count still moves one word.
  function automatic logic [SPI_COUNT_W-1:0] eff_count(input logic [SPI_COUNT_W-1:0] c);
    return (c == '0) ? SPI_COUNT_W'(1) : c;
  endfunction
endpackage

// File: rtl/spi_burst_controller_if.sv
// Host command/data port plus the spi_master-facing signals of the burst controller.
interface spi_burst_controller_if;
  import spi_ctrl_pkg::*;

  logic                   i_cmd_valid;
  logic                   o_cmd_ready;
  logic [SPI_ADDR_W-1:0]  i_cmd_addr;
  logic                   i_cmd_rw;
  logic [SPI_COUNT_W-1:0] i_cmd_count;
  logic [SPI_DATA_W-1:0]  i_wr_data;
  logic                   i_wr_valid;
  logic                   o_wr_ready;
  logic [SPI_DATA_W-1:0]  o_rd_data;
  logic                   o_rd_valid;
  logic                   i_rd_ready;
  logic                   o_done;
  logic                   o_underflow_err;
  logic                   o_overflow_err;
  logic                   i_err_clear;
  logic                   o_spi_enable;
  logic [SPI_ADDR_W-1:0]  o_spi_addr;
  logic                   o_spi_rw;
  logic [SPI_DATA_W-1:0]  o_spi_data;
  logic                   o_spi_burst_enable;
  logic [SPI_COUNT_W-1:0] o_spi_burst_count;
  logic                   i_spi_busy;
  logic [SPI_DATA_W-1:0]  i_spi_read_word;
  logic                   i_spi_burst_read_valid;
  logic                   i_spi_burst_write_req;

  modport slave (
    input  i_cmd_valid, i_cmd_addr, i_cmd_rw, i_cmd_count, i_wr_data, i_wr_valid,
           i_rd_ready, i_err_clear, i_spi_busy, i_spi_read_word,
           i_spi_burst_read_valid, i_spi_burst_write_req,
    output o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid, o_done, o_underflow_err,
           o_overflow_err, o_spi_enable, o_spi_addr, o_spi_rw, o_spi_data,
           o_spi_burst_enable, o_spi_burst_count
  );

  modport master (
    output i_cmd_valid, i_cmd_addr, i_cmd_rw, i_cmd_count, i_wr_data, i_wr_valid,
           i_rd_ready, i_err_clear, i_spi_busy, i_spi_read_word,
           i_spi_burst_read_valid, i_spi_burst_write_req,
    input  o_cmd_ready, o_wr_ready, o_rd_data, o_rd_valid, o_done, o_underflow_err,
           o_overflow_err, o_spi_enable, o_spi_addr, o_spi_rw, o_spi_data,
           o_spi_burst_enable, o_spi_burst_count
  );
endinterface

// File: rtl/spi_burst_controller_sync_fifo.sv
// First-word-fall-through FIFO; head is visible whenever not empty.
// Push when full and pop when empty are silently ignored.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE_CNT  = (AW+1)'(1);
  localparam logic [AW-1:0] ONE_PTR  = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign o_full  = (count == FULL_CNT);
  assign o_empty = (count == '0);
  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;
  assign o_data  = mem[rd_ptr];

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE_PTR;
      if (do_pop)  rd_ptr <= rd_ptr + ONE_PTR;
      case ({do_push, do_pop})
        2'b10:   count <= count + ONE_CNT;
        2'b01:   count <= count - ONE_CNT;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/spi_burst_controller.sv
// Command/buffer stage in front of spi_master: latches host commands, feeds burst
// write words from a write FIFO and collects read words into a read FIFO.
module spi_burst_controller
  import spi_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = 4
) (
  input logic                  i_clk,
  input logic                  i_rst,
  spi_burst_controller_if.slave bus
);
  state_t                 state;
  logic                   busy_q, rvld_q, wreq_q;
  logic                   busy_rise, busy_fall, rvld_rise, wreq_rise;
  logic [SPI_DATA_W-1:0]  wf_head;
  logic                   wf_full, wf_empty, wf_pop;
  logic                   rf_full, rf_empty, rf_push;
  logic                   under_set, over_set;
  logic [SPI_COUNT_W-1:0] cmd_eff;

  assign busy_rise = bus.i_spi_busy & ~busy_q;
  assign busy_fall = ~bus.i_spi_busy & busy_q;
  assign rvld_rise = bus.i_spi_burst_read_valid & ~rvld_q;
  assign wreq_rise = bus.i_spi_burst_write_req & ~wreq_q;
  assign cmd_eff   = eff_count(bus.i_cmd_count);

  assign wf_pop    = ~wf_empty & ((state == PREFETCH) | ((state == RUN) & wreq_rise));
  // Burst reads arrive on read-valid strobes; a single read lands when busy drops.
  assign rf_push   = (state == RUN) & bus.o_spi_rw &
                     (bus.o_spi_burst_enable ? rvld_rise : busy_fall);
  assign under_set = (state == RUN) & wreq_rise & wf_empty;
  assign over_set  = rf_push & rf_full;

  assign bus.o_wr_ready = ~wf_full;
  assign bus.o_rd_valid = ~rf_empty;

  sync_fifo #(.WIDTH(SPI_DATA_W), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_wr_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (bus.i_wr_valid),
    .i_data  (bus.i_wr_data),
    .i_pop   (wf_pop),
    .o_data  (wf_head),
    .o_full  (wf_full),
    .o_empty (wf_empty)
  );

  sync_fifo #(.WIDTH(SPI_DATA_W), .DEPTH(FIFO_DEPTH), .AW(FIFO_AW)) u_rd_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (rf_push),
    .i_data  (bus.i_spi_read_word),
    .i_pop   (bus.i_rd_ready),
    .o_data  (bus.o_rd_data),
    .o_full  (rf_full),
    .o_empty (rf_empty)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state                  <= IDLE;
      busy_q                 <= 1'b0;
      rvld_q                 <= 1'b0;
      wreq_q                 <= 1'b0;
      bus.o_cmd_ready        <= 1'b1;
      bus.o_done             <= 1'b0;
      bus.o_spi_enable       <= 1'b0;
      bus.o_spi_addr         <= '0;
      bus.o_spi_rw           <= 1'b0;
      bus.o_spi_data         <= '0;
      bus.o_spi_burst_enable <= 1'b0;
      bus.o_spi_burst_count  <= '0;
      bus.o_underflow_err    <= 1'b0;
      bus.o_overflow_err     <= 1'b0;
    end else begin
      busy_q     <= bus.i_spi_busy;
      rvld_q     <= bus.i_spi_burst_read_valid;
      wreq_q     <= bus.i_spi_burst_write_req;
      bus.o_done <= 1'b0;

      // A new error event beats a coincident clear.
      if (under_set)            bus.o_underflow_err <= 1'b1;
      else if (bus.i_err_clear) bus.o_underflow_err <= 1'b0;
      if (over_set)             bus.o_overflow_err  <= 1'b1;
      else if (bus.i_err_clear) bus.o_overflow_err  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.i_cmd_valid & bus.o_cmd_ready) begin
            bus.o_cmd_ready        <= 1'b0;
            bus.o_spi_addr         <= bus.i_cmd_addr;
            bus.o_spi_rw           <= bus.i_cmd_rw;
            bus.o_spi_burst_count  <= cmd_eff;
            bus.o_spi_burst_enable <= (cmd_eff > SPI_COUNT_W'(1));
            if (bus.i_cmd_rw) begin
              bus.o_spi_data   <= '0;
              bus.o_spi_enable <= 1'b1;
              state            <= START;
            end else begin
              state <= PREFETCH;
            end
          end
        end
        PREFETCH: begin
          if (!wf_empty) begin
            bus.o_spi_data   <= wf_head;
            bus.o_spi_enable <= 1'b1;
            state            <= START;
          end
        end
        START: begin
          // Drop enable as soon as the master is seen busy so it does not restart.
          if (busy_rise) begin
            bus.o_spi_enable <= 1'b0;
            state            <= RUN;
          end
        end
        RUN: begin
          if (wreq_rise) bus.o_spi_data <= wf_empty ? '0 : wf_head;
          if (busy_fall) begin
            bus.o_done <= 1'b1;
            state      <= DONE;
          end
        end
        DONE: begin
          bus.o_cmd_ready <= 1'b1;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_burst_controller.sv
// Randomised bench for spi_burst_controller with a queue-based reference model.
module tb_spi_burst_controller;
  import spi_ctrl_pkg::*;

  localparam int DEPTH    = 4;
  localparam int PH_IDLE  = 0;
  localparam int PH_PRE   = 1;
  localparam int PH_START = 2;
  localparam int PH_RUN   = 3;
  localparam int PH_DONE  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_burst_controller_if bus();

  spi_burst_controller #(.FIFO_DEPTH(DEPTH), .FIFO_AW(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  int          ph;
  logic [15:0] wq[$];
  logic [15:0] rq[$];
  logic [15:0] e_data, e_bcnt;
  logic [14:0] e_addr;
  logic        e_rw, e_ben, e_under, e_over;
  logic        p_busy, p_rv, p_wreq;
  bit          host_rand = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name, input int want_ph);
    total++;
    bad++;
    $display("FAIL timeout %s: model phase %0d want %0d", name, ph, want_ph);
  endtask

  task automatic model_reset();
    ph = PH_IDLE;
    wq.delete();
    rq.delete();
    e_data = '0; e_bcnt = '0; e_addr = '0; e_rw = 0; e_ben = 0;
    e_under = 0; e_over = 0; p_busy = 0; p_rv = 0; p_wreq = 0;
  endtask

  // One clock of the spec's rules, evaluated on the inputs present at the edge.
  task automatic model_step();
    bit w_empty, w_full, r_empty, r_full, b_rise, b_fall, v_rise, q_rise;
    bit push_r, pop_w, u_set, o_set;
    if (rst) begin
      model_reset();
      return;
    end
    w_empty = (wq.size() == 0);
    w_full  = (wq.size() == DEPTH);
    r_empty = (rq.size() == 0);
    r_full  = (rq.size() == DEPTH);
    b_rise  = bus.i_spi_busy && !p_busy;
    b_fall  = !bus.i_spi_busy && p_busy;
    v_rise  = bus.i_spi_burst_read_valid && !p_rv;
    q_rise  = bus.i_spi_burst_write_req && !p_wreq;
    push_r = 0; pop_w = 0; u_set = 0; o_set = 0;
    case (ph)
      PH_IDLE: if (bus.i_cmd_valid) begin
        e_addr = bus.i_cmd_addr;
        e_rw   = bus.i_cmd_rw;
        e_bcnt = (bus.i_cmd_count == 0) ? 16'd1 : bus.i_cmd_count;
        e_ben  = (e_bcnt > 1);
        if (e_rw) begin e_data = '0; ph = PH_START; end
        else ph = PH_PRE;
      end
      PH_PRE: if (!w_empty) begin e_data = wq[0]; pop_w = 1; ph = PH_START; end
      PH_START: if (b_rise) ph = PH_RUN;
      PH_RUN: begin
        if (q_rise) begin
          if (w_empty) begin e_data = '0; u_set = 1; end
          else begin e_data = wq[0]; pop_w = 1; end
        end
        if (e_rw && e_ben && v_rise) push_r = 1;
        if (e_rw && !e_ben && b_fall) push_r = 1;
        if (b_fall) ph = PH_DONE;
      end
      default: ph = PH_IDLE;
    endcase
    if (push_r && r_full) o_set = 1;
    if (u_set) e_under = 1; else if (bus.i_err_clear) e_under = 0;
    if (o_set) e_over = 1;  else if (bus.i_err_clear) e_over = 0;
    if (bus.i_rd_ready && !r_empty) void'(rq.pop_front());
    if (push_r && !r_full) rq.push_back(bus.i_spi_read_word);
    if (pop_w) void'(wq.pop_front());
    if (bus.i_wr_valid && !w_full) wq.push_back(bus.i_wr_data);
    p_busy = bus.i_spi_busy;
    p_rv   = bus.i_spi_burst_read_valid;
    p_wreq = bus.i_spi_burst_write_req;
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    check("cmd_ready", 32'(bus.o_cmd_ready), 32'(ph == PH_IDLE));
    check("spi_enable", 32'(bus.o_spi_enable), 32'(ph == PH_START));
    check("done", 32'(bus.o_done), 32'(ph == PH_DONE));
    check("wr_ready", 32'(bus.o_wr_ready), 32'(wq.size() < DEPTH));
    check("rd_valid", 32'(bus.o_rd_valid), 32'(rq.size() > 0));
    if (rq.size() > 0) check("rd_data", 32'(bus.o_rd_data), 32'(rq[0]));
    check("spi_data", 32'(bus.o_spi_data), 32'(e_data));
    check("spi_addr", 32'(bus.o_spi_addr), 32'(e_addr));
    check("spi_rw", 32'(bus.o_spi_rw), 32'(e_rw));
    check("burst_en", 32'(bus.o_spi_burst_enable), 32'(e_ben));
    check("burst_cnt", 32'(bus.o_spi_burst_count), 32'(e_bcnt));
    check("underflow", 32'(bus.o_underflow_err), 32'(e_under));
    check("overflow", 32'(bus.o_overflow_err), 32'(e_over));
  end

  task automatic cycle();
    if (host_rand) begin
      bus.i_wr_valid  = 1'($urandom_range(0, 1));
      bus.i_wr_data   = 16'($urandom);
      bus.i_rd_ready  = 1'($urandom_range(0, 1));
      bus.i_err_clear = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic wait_ph(input int target, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (ph == target) return;
      cycle();
    end
    if (ph != target) timeout("wait_phase", target);
  endtask

  task automatic push_word(input logic [15:0] d);
    bus.i_wr_valid = 1'b1;
    bus.i_wr_data  = d;
    cycle();
    bus.i_wr_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [14:0] a, input logic r, input logic [15:0] c);
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = a;
    bus.i_cmd_rw    = r;
    bus.i_cmd_count = c;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (ph != PH_IDLE) break;
    end
    bus.i_cmd_valid = 1'b0;
    if (ph == PH_IDLE) timeout("cmd_accept", PH_PRE);
  endtask

  // Behaviour of spi_master as seen by the controller.
  task automatic run_master(input logic r, input int eff, input logic [15:0] base);
    wait_ph(PH_START, 300);
    repeat ($urandom_range(0, 2)) cycle();
    bus.i_spi_busy = 1'b1;
    cycle();
    if (!r && eff > 1) begin
      for (int k = 1; k < eff; k++) begin
        repeat ($urandom_range(0, 1)) cycle();
        bus.i_spi_burst_write_req = 1'b1;
        cycle();
        bus.i_spi_burst_write_req = 1'b0;
        cycle();
      end
    end
    if (r && eff > 1) begin
      for (int k = 0; k < eff; k++) begin
        bus.i_spi_read_word        = base + 16'(k);
        bus.i_spi_burst_read_valid = 1'b1;
        cycle();
        bus.i_spi_burst_read_valid = 1'b0;
        cycle();
      end
    end
    if (r && eff == 1) bus.i_spi_read_word = base;
    repeat ($urandom_range(0, 1)) cycle();
    bus.i_spi_busy = 1'b0;
    cycle();
    cycle();
  endtask

  task automatic drain_check(input logic [15:0] base, input int n);
    for (int k = 0; k < n; k++) begin
      check("drain_word", 32'(bus.o_rd_data), 32'(base + 16'(k)));
      bus.i_rd_ready = 1'b1;
      cycle();
      bus.i_rd_ready = 1'b0;
    end
    check("drain_empty", 32'(bus.o_rd_valid), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    logic r;
    int   c;
    bus.i_cmd_valid = 0; bus.i_cmd_addr = '0; bus.i_cmd_rw = 0; bus.i_cmd_count = '0;
    bus.i_wr_data = '0; bus.i_wr_valid = 0; bus.i_rd_ready = 0; bus.i_err_clear = 0;
    bus.i_spi_busy = 0; bus.i_spi_read_word = '0;
    bus.i_spi_burst_read_valid = 0; bus.i_spi_burst_write_req = 0;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
    check("reset_cmd_ready", 32'(bus.o_cmd_ready), 32'(1));
    check("reset_wr_ready", 32'(bus.o_wr_ready), 32'(1));
    cycle();

    // Single write
    push_word(16'hBEEF);
    send_cmd(15'h1234, 1'b0, 16'd1);
    wait_ph(PH_START, 20);
    check("single_data", 32'(bus.o_spi_data), 32'(16'hBEEF));
    check("single_addr", 32'(bus.o_spi_addr), 32'(15'h1234));
    check("single_ben", 32'(bus.o_spi_burst_enable), 32'(0));
    run_master(1'b0, 1, 16'h0);
    check("single_idle", 32'(bus.o_cmd_ready), 32'(1));

    // Burst write, three words
    push_word(16'h0001); push_word(16'h0002); push_word(16'h0003);
    send_cmd(15'h0100, 1'b0, 16'd3);
    wait_ph(PH_START, 20);
    check("bw_ben", 32'(bus.o_spi_burst_enable), 32'(1));
    check("bw_cnt", 32'(bus.o_spi_burst_count), 32'(3));
    check("bw_first", 32'(bus.o_spi_data), 32'(16'h0001));
    run_master(1'b0, 3, 16'h0);
    check("bw_last", 32'(bus.o_spi_data), 32'(16'h0003));
    check("bw_no_under", 32'(bus.o_underflow_err), 32'(0));

    // Write FIFO full: fifth push ignored
    for (int k = 0; k < 5; k++) push_word(16'h0010 + 16'(k));
    check("wf_full", 32'(bus.o_wr_ready), 32'(0));
    send_cmd(15'h0200, 1'b0, 16'd4);
    run_master(1'b0, 4, 16'h0);
    check("wf_last", 32'(bus.o_spi_data), 32'(16'h0013));
    check("wf_no_under", 32'(bus.o_underflow_err), 32'(0));

    // Burst write underflow
    push_word(16'h5555);
    send_cmd(15'h0300, 1'b0, 16'd2);
    run_master(1'b0, 2, 16'h0);
    check("uf_data", 32'(bus.o_spi_data), 32'(16'h0000));
    check("uf_err", 32'(bus.o_underflow_err), 32'(1));
    cycle();
    check("uf_sticky", 32'(bus.o_underflow_err), 32'(1));
    bus.i_err_clear = 1'b1; cycle(); bus.i_err_clear = 1'b0;
    check("uf_cleared", 32'(bus.o_underflow_err), 32'(0));

    // Burst read of four words fills the FIFO exactly
    send_cmd(15'h0042, 1'b1, 16'd4);
    check("br_data0", 32'(bus.o_spi_data), 32'(0));
    run_master(1'b1, 4, 16'hA000);
    check("br_valid", 32'(bus.o_rd_valid), 32'(1));
    check("br_no_over", 32'(bus.o_overflow_err), 32'(0));
    drain_check(16'hA000, 4);

    // Read overflow: fifth word dropped
    send_cmd(15'h0043, 1'b1, 16'd5);
    run_master(1'b1, 5, 16'hB000);
    check("of_err", 32'(bus.o_overflow_err), 32'(1));
    drain_check(16'hB000, 4);
    bus.i_err_clear = 1'b1; cycle(); bus.i_err_clear = 1'b0;

    // Count of zero behaves as a single read
    send_cmd(15'h0044, 1'b1, 16'd0);
    check("z_cnt", 32'(bus.o_spi_burst_count), 32'(1));
    check("z_ben", 32'(bus.o_spi_burst_enable), 32'(0));
    run_master(1'b1, 1, 16'hC0DE);
    drain_check(16'hC0DE, 1);

    // Randomised traffic
    host_rand = 1;
    for (int t = 0; t < 40; t++) begin
      r = 1'($urandom_range(0, 1));
      c = $urandom_range(0, 6);
      send_cmd(15'($urandom), r, 16'(c));
      run_master(r, (c == 0) ? 1 : c, 16'($urandom));
    end
    host_rand = 0;
    bus.i_wr_valid = 0; bus.i_rd_ready = 0; bus.i_err_clear = 0;
    bus.i_rd_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
    bus.i_rd_ready = 1'b0;

    // Async reset while the master is running
    send_cmd(15'h0055, 1'b1, 16'd3);
    wait_ph(PH_START, 20);
    bus.i_spi_busy = 1'b1;
    cycle();
    bus.i_spi_read_word = 16'h7777;
    bus.i_spi_burst_read_valid = 1'b1;
    cycle();
    bus.i_spi_burst_read_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.o_rd_valid), 32'(1));
    rst = 1'b1;
    bus.i_spi_busy = 1'b0;
    model_reset();
    #1;
    check("rst_enable", 32'(bus.o_spi_enable), 32'(0));
    check("rst_cmd_ready", 32'(bus.o_cmd_ready), 32'(1));
    check("rst_rd_valid", 32'(bus.o_rd_valid), 32'(0));
    check("rst_done", 32'(bus.o_done), 32'(0));
    cycle();
    rst = 1'b0;
    cycle();
    check("post_rst_done", 32'(bus.o_done), 32'(0));
    check("post_rst_ready", 32'(bus.o_cmd_ready), 32'(1));
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
